// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: fetch, resolution, ras and prediction signals of the return-address-stack front-end controller.
interface ras_ctrl_if #(parameter int WIDTH = 32);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] fetch_pc;
  logic [31:0]      fetch_instr;
  logic             resolve_valid;
  logic             resolve_mispredict;
  logic             resolve_ready;
  logic [WIDTH-1:0] ras_dout;
  logic             ras_empty;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_branch;
  logic             ras_close_valid;
  logic             ras_close_invalid;
  logic [WIDTH-1:0] ras_din;
  logic             pred_valid;
  logic [WIDTH-1:0] pred_target;
  modport master (
    output fetch_valid, fetch_pc, fetch_instr, resolve_valid, resolve_mispredict, ras_dout, ras_empty,
    input  fetch_ready, resolve_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
           ras_din, pred_valid, pred_target
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, resolve_valid, resolve_mispredict, ras_dout, ras_empty,
    output fetch_ready, resolve_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
           ras_din, pred_valid, pred_target
  );
endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl: predecodes fetched instructions into ras push/pop/branch strobes and sequences closes/invalidates.
module ras_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 128,
  parameter int RVC          = 1
) (
  input logic     clk,
  input logic     rst_ni,
  ras_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_BRANCHES + 1);
  typedef enum logic [1:0] {START, RUN, DRAIN, INV} state_t;
  state_t        state;
  logic          start_cnt;
  logic          gap;
  logic          pred_valid;
  logic [CW-1:0] open_cnt;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] open_nxt;
  logic [CW-1:0] pend_nxt;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [3:0] c_hi;
  logic [4:0] c_rs2;
  logic [1:0] q;
  logic is32, rvc, jal, jalr, br, cj, cjr, cjalr, cjal, cbr;
  logic acc, push, pop, branch, close, res_acc, err, correct, mis;
  assign op    = bus.fetch_instr[6:0];
  assign f3    = bus.fetch_instr[14:12];
  assign rd    = bus.fetch_instr[11:7];
  assign rs1   = bus.fetch_instr[19:15];
  assign c_hi  = bus.fetch_instr[15:12];
  assign c_rs2 = bus.fetch_instr[6:2];
  assign q     = bus.fetch_instr[1:0];
  function automatic logic link(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction
  // Compressed fields share bit positions with rd; rd doubles as c.jr/c.jalr rs1.
  assign is32  = q == 2'b11;
  assign rvc   = RVC != 0 && !is32;
  assign jal   = is32 && op == 7'b1101111;
  assign jalr  = is32 && op == 7'b1100111 && f3 == 3'b000;
  assign br    = is32 && op == 7'b1100011;
  assign cj    = rvc && q == 2'b10 && c_hi[3:1] == 3'b100 && c_rs2 == 5'd0 && rd != 5'd0;
  assign cjr   = cj && !c_hi[0];
  assign cjalr = cj && c_hi[0];
  assign cjal  = rvc && q == 2'b01 && c_hi[3:1] == 3'b001;
  assign cbr   = rvc && q == 2'b01 && c_hi[3:2] == 2'b11;
  assign bus.fetch_ready   = state == RUN && open_cnt < CW'(MAX_BRANCHES) &&
                             !(bus.resolve_valid && bus.resolve_mispredict);
  assign bus.resolve_ready = state == RUN;
  assign acc    = bus.fetch_valid && bus.fetch_ready;
  assign push   = acc && ((jal || jalr) && link(rd) || cjal || cjalr);
  assign pop    = acc && (jalr && link(rs1) && (!link(rd) || rd != rs1) || cjr && link(rd) || cjalr && rd == 5'd5);
  assign branch = acc && (br || cbr);
  assign res_acc = bus.resolve_valid && bus.resolve_ready;
  assign err     = open_cnt == pend_cnt;
  assign correct = res_acc && !bus.resolve_mispredict && !err;
  assign mis     = res_acc && bus.resolve_mispredict && !err;
  assign close    = (state == RUN || state == DRAIN) && pend_cnt != '0 && !gap && !branch;
  assign pend_nxt = pend_cnt + CW'(correct) - CW'(close);
  assign open_nxt = open_cnt + CW'(branch) - CW'(close);
  assign bus.ras_push          = push;
  assign bus.ras_pop           = pop;
  assign bus.ras_branch        = branch;
  assign bus.ras_close_valid   = close;
  assign bus.ras_close_invalid = state == INV;
  assign bus.ras_din           = bus.fetch_pc + WIDTH'(rvc ? 2 : 4);
  assign bus.pred_valid        = pred_valid;
  assign bus.pred_target       = bus.ras_dout;
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= START;
      start_cnt  <= 1'b0;
      gap        <= 1'b0;
      pred_valid <= 1'b0;
      open_cnt   <= '0;
      pend_cnt   <= '0;
    end else begin
      gap        <= close;
      pred_valid <= pop && !bus.ras_empty;
      open_cnt   <= open_nxt;
      pend_cnt   <= pend_nxt;
      case (state)
        START: begin
          start_cnt <= 1'b1;
          if (start_cnt) state <= RUN;
        end
        // A close in the mispredict cycle still routes via DRAIN so its gap cycle precedes the invalidate.
        RUN:   if (mis) state <= (pend_nxt != '0 || close) ? DRAIN : INV;
        DRAIN: if (pend_nxt == '0 && !close) state <= INV;
        default: begin
          open_cnt <= '0;
          pend_cnt <= '0;
          state    <= RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed checks of ras_ctrl decode, close spacing, mispredict drain, branch limit and reset.
module tb_ras_ctrl;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL1  = 32'h0000_00EF;
  localparam logic [31:0] RET   = 32'h0000_8067;
  localparam logic [31:0] JALR15 = 32'h0002_80E7;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] CJAL  = 32'h0000_2001;
  localparam logic [31:0] CJR1  = 32'h0000_8082;
  localparam logic [31:0] CJALR5 = 32'h0000_9282;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  ras_ctrl_if #(.WIDTH(32)) bus ();
  ras_ctrl #(.WIDTH(32), .MAX_BRANCHES(4), .RVC(1)) dut (.clk(clk), .rst_ni(rst_ni), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_instr = instr;
  endtask
  task automatic resolve(input logic v, input logic m);
    bus.resolve_valid      = v;
    bus.resolve_mispredict = m;
  endtask
  task automatic reset_startup(input string tag);
    @(negedge clk);
    check({tag, "_start0_ready"}, bus.fetch_ready, 0);
    check({tag, "_start0_push"}, bus.ras_push, 0);
    nxt;
    @(negedge clk);
    check({tag, "_start1_ready"}, bus.fetch_ready, 0);
    check({tag, "_start1_branch"}, bus.ras_branch, 0);
    nxt;
    @(negedge clk);
    check({tag, "_run_ready"}, bus.fetch_ready, 1);
    check({tag, "_run_res_ready"}, bus.resolve_ready, 1);
  endtask
  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_pc = '0;
    bus.fetch_instr = NOP;
    resolve(0, 0);
    bus.ras_dout = '0;
    bus.ras_empty = 1'b1;
    #1 rst_ni = 1'b0;
    fetch(32'h100, JAL1);
    @(negedge clk);
    check("rst_fetch_ready", bus.fetch_ready, 0);
    check("rst_resolve_ready", bus.resolve_ready, 0);
    check("rst_push", bus.ras_push, 0);
    nxt;
    rst_ni = 1'b1;
    reset_startup("boot");
    check("jal_push", bus.ras_push, 1);
    check("jal_din", bus.ras_din, 32'h104);
    check("jal_pop", bus.ras_pop, 0);
    nxt;
    fetch(32'h104, RET);
    bus.ras_empty = 1'b0;
    bus.ras_dout = 32'h104;
    @(negedge clk);
    check("ret_pop", bus.ras_pop, 1);
    check("ret_push", bus.ras_push, 0);
    nxt;
    fetch(32'h200, CJAL);
    @(negedge clk);
    check("pred_valid", bus.pred_valid, 1);
    check("pred_target", bus.pred_target, 32'h104);
    check("cjal_push", bus.ras_push, 1);
    check("cjal_din", bus.ras_din, 32'h202);
    nxt;
    fetch(32'h300, JALR15);
    @(negedge clk);
    check("jalr15_push", bus.ras_push, 1);
    check("jalr15_pop", bus.ras_pop, 1);
    check("jalr15_din", bus.ras_din, 32'h304);
    check("pred_after_nopop", bus.pred_valid, 0);
    nxt;
    fetch(32'h400, CJALR5);
    @(negedge clk);
    check("cjalr5_push", bus.ras_push, 1);
    check("cjalr5_pop", bus.ras_pop, 1);
    check("cjalr5_din", bus.ras_din, 32'h402);
    nxt;
    bus.ras_empty = 1'b1;
    fetch(32'h500, CJR1);
    @(negedge clk);
    check("cjr_pop", bus.ras_pop, 1);
    check("cjr_push", bus.ras_push, 0);
    check("pred_after_pop", bus.pred_valid, 1);
    nxt;
    fetch(32'h502, NOP);
    @(negedge clk);
    check("pred_empty_pop", bus.pred_valid, 0);
    check("nop_push", bus.ras_push, 0);
    check("nop_pop", bus.ras_pop, 0);
    check("nop_branch", bus.ras_branch, 0);
    // three open branches, three back-to-back correct resolutions
    for (int i = 0; i < 3; i++) begin
      nxt;
      fetch(32'h600 + 4 * i, BEQ);
      @(negedge clk);
      check($sformatf("br%0d_branch", i), bus.ras_branch, 1);
    end
    for (int i = 0; i < 7; i++) begin
      nxt;
      bus.fetch_valid = 1'b0;
      resolve(i < 3, 0);
      @(negedge clk);
      check($sformatf("spacing_close%0d", i), bus.ras_close_valid, (i % 2) == 1);
    end
    // branch during a pending close defers it by one cycle
    for (int i = 0; i < 2; i++) begin
      nxt;
      fetch(32'h700 + 4 * i, BEQ);
      @(negedge clk);
    end
    for (int i = 0; i < 7; i++) begin
      nxt;
      resolve(i < 2, 0);
      bus.fetch_valid = (i == 3);
      bus.fetch_instr = BEQ;
      @(negedge clk);
      check($sformatf("defer_close%0d", i), bus.ras_close_valid, i == 1 || i == 4);
      if (i == 3) check("defer_branch", bus.ras_branch, 1);
    end
    // build pend_cnt=2 with branches blocking closes, then mispredict
    nxt;
    fetch(32'h800, BEQ);
    resolve(1, 0);
    @(negedge clk);
    check("pre_mis_branch0", bus.ras_branch, 1);
    nxt;
    fetch(32'h804, BEQ);
    @(negedge clk);
    check("pre_mis_branch1", bus.ras_branch, 1);
    check("pre_mis_close", bus.ras_close_valid, 0);
    nxt;
    fetch(32'h808, BEQ);
    resolve(1, 1);
    @(negedge clk);
    check("mis_fetch_ready", bus.fetch_ready, 0);
    check("mis_branch", bus.ras_branch, 0);
    check("mis_close", bus.ras_close_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      nxt;
      resolve(0, 0);
      @(negedge clk);
      check($sformatf("drain%0d_close", i), bus.ras_close_valid, i == 2);
      check($sformatf("drain%0d_inv", i), bus.ras_close_invalid, i == 4);
      check($sformatf("drain%0d_fetch_ready", i), bus.fetch_ready, 0);
      check($sformatf("drain%0d_res_ready", i), bus.resolve_ready, 0);
    end
    nxt;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    check("post_inv_ready", bus.fetch_ready, 1);
    check("post_inv_inv", bus.ras_close_invalid, 0);
    // open_cnt was cleared: exactly four branches fit
    for (int i = 0; i < 4; i++) begin
      nxt;
      fetch(32'h900 + 4 * i, BEQ);
      @(negedge clk);
      check($sformatf("fill%0d_ready", i), bus.fetch_ready, 1);
    end
    nxt;
    @(negedge clk);
    check("full_ready", bus.fetch_ready, 0);
    check("full_branch", bus.ras_branch, 0);
    nxt;
    bus.fetch_valid = 1'b0;
    resolve(1, 0);
    @(negedge clk);
    check("full_res_ready", bus.fetch_ready, 0);
    nxt;
    resolve(0, 0);
    @(negedge clk);
    check("full_close", bus.ras_close_valid, 1);
    check("full_close_ready", bus.fetch_ready, 0);
    nxt;
    @(negedge clk);
    check("freed_ready", bus.fetch_ready, 1);
    // reach DRAIN, then reset in the middle of a close
    nxt;
    fetch(32'hA00, BEQ);
    resolve(1, 0);
    @(negedge clk);
    check("r6_branch", bus.ras_branch, 1);
    nxt;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    check("r6_close", bus.ras_close_valid, 1);
    nxt;
    resolve(1, 1);
    @(negedge clk);
    check("r6_mis_close", bus.ras_close_valid, 0);
    nxt;
    resolve(0, 0);
    @(negedge clk);
    check("r6_drain_close", bus.ras_close_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("r6_rst_close", bus.ras_close_valid, 0);
    check("r6_rst_inv", bus.ras_close_invalid, 0);
    check("r6_rst_res_ready", bus.resolve_ready, 0);
    nxt;
    rst_ni = 1'b1;
    reset_startup("redo");
    check("redo_close", bus.ras_close_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
